sq_bcd_accum: RTL and testbench

SQ_BCD_ACCUM -- requirements
Module: sq_bcd_accum

---
 rtl/sq_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/sq_bcd_accum.sv | 118 +++++++++++
 tb/tb_sq_bcd_accum.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// Shared types and constants for the squared-value BCD accumulator.
package sq_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int unsigned BCD_W   = 12;
   localparam logic [3:0]  ADD3_TH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_digit_adj
   import sq_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= ADD3_TH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/sq_bcd_accum.sv
// Accumulates a group of squared values, then converts the sum to 3-digit BCD.
// Optional saturation with overflow flag: define SQBCD_SAT_EN.
module sq_bcd_accum
   import sq_pkg::*;
#(
   parameter int unsigned ACC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        sq_in,
   input  logic              sq_valid,
   input  logic              sq_last,
   output logic              sq_ready,
   output logic [BCD_W-1:0]  bcd_out,
   output logic              bcd_valid,
   input  logic              bcd_ready
`ifdef SQBCD_SAT_EN
   ,
   output logic              ovf
`endif
);

   localparam int unsigned SR_W = BCD_W + ACC_W;

   state_t              state_q;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [SR_W-1:0]     sr_q, sr_d;
   logic [3:0]          cnt_q;
   logic [BCD_W-1:0]    bcd_out_q;
   logic                bcd_valid_q;
   logic [BCD_W-1:0]    bcd_adj;

`ifdef SQBCD_SAT_EN
   logic [ACC_W:0]      sum_ext;
   logic                sticky_q, ovf_q, ovf_d;

   assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(sq_in);
   assign acc_d   = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
   assign ovf_d   = sticky_q | sum_ext[ACC_W];
   assign ovf     = ovf_q;
`else
   assign acc_d = acc_q + ACC_W'(sq_in);
`endif

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit_i (sr_q[ACC_W + 4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   // The digit field's top bit is shifted out; it is always zero for sums below 1000.
   assign sr_d = {bcd_adj, sr_q[ACC_W-1:0]} << 1;

   assign sq_ready  = (state_q == ACCUM);
   assign bcd_out   = bcd_out_q;
   assign bcd_valid = bcd_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         sr_q        <= '0;
         cnt_q       <= '0;
         bcd_out_q   <= '0;
         bcd_valid_q <= 1'b0;
`ifdef SQBCD_SAT_EN
         sticky_q    <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ACCUM: begin
               if (sq_valid) begin
`ifdef SQBCD_SAT_EN
                  sticky_q <= ovf_d;
`endif
                  if (sq_last) begin
                     sr_q    <= {{BCD_W{1'b0}}, acc_d};
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= CONVERT;
                  end else begin
                     acc_q <= acc_d;
                  end
               end
            end
            CONVERT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'(ACC_W - 1)) begin
                  bcd_out_q   <= sr_d[SR_W-1 -: BCD_W];
                  bcd_valid_q <= 1'b1;
`ifdef SQBCD_SAT_EN
                  ovf_q       <= sticky_q;
`endif
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bcd_ready) begin
                  bcd_valid_q <= 1'b0;
`ifdef SQBCD_SAT_EN
                  ovf_q       <= 1'b0;
                  sticky_q    <= 1'b0;
`endif
                  state_q     <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_sq_bcd_accum.sv
// Directed self-checking bench for sq_bcd_accum (ACC_W=8 and ACC_W=4 instances).
module tb_sq_bcd_accum;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [3:0]  sq_in8, sq_in4;
   logic        sq_valid8, sq_valid4, sq_last8, sq_last4;
   logic        sq_ready8, sq_ready4;
   logic [11:0] bcd_out8, bcd_out4;
   logic        bcd_valid8, bcd_valid4;
   logic        bcd_ready8, bcd_ready4;
`ifdef SQBCD_SAT_EN
   logic        ovf8, ovf4;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   always #5 clk = ~clk;

   sq_bcd_accum #(.ACC_W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sq_in     (sq_in8),
      .sq_valid  (sq_valid8),
      .sq_last   (sq_last8),
      .sq_ready  (sq_ready8),
      .bcd_out   (bcd_out8),
      .bcd_valid (bcd_valid8),
      .bcd_ready (bcd_ready8)
`ifdef SQBCD_SAT_EN
      ,
      .ovf       (ovf8)
`endif
   );

   sq_bcd_accum #(.ACC_W(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .sq_in     (sq_in4),
      .sq_valid  (sq_valid4),
      .sq_last   (sq_last4),
      .sq_ready  (sq_ready4),
      .bcd_out   (bcd_out4),
      .bcd_valid (bcd_valid4),
      .bcd_ready (bcd_ready4)
`ifdef SQBCD_SAT_EN
      ,
      .ovf       (ovf4)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit sel4, input logic [3:0] v, input logic last);
      if (sel4) begin
         sq_valid4 = 1'b1; sq_in4 = v; sq_last4 = last;
      end else begin
         sq_valid8 = 1'b1; sq_in8 = v; sq_last8 = last;
      end
      step();
      sq_valid4 = 1'b0; sq_last4 = 1'b0;
      sq_valid8 = 1'b0; sq_last8 = 1'b0;
   endtask

   // Counts edges after the sq_last accept until bcd_valid rises (bounded).
   task automatic wait_valid(input bit sel4, output int n);
      n = 0;
      while (((sel4 ? bcd_valid4 : bcd_valid8) !== 1'b1) && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sq_in8 = '0; sq_valid8 = 1'b0; sq_last8 = 1'b0; bcd_ready8 = 1'b1;
      sq_in4 = '0; sq_valid4 = 1'b0; sq_last4 = 1'b0; bcd_ready4 = 1'b1;
      step();
      step();
      check("rst_sq_ready", 32'(sq_ready8), 32'd1);
      check("rst_bcd_valid", 32'(bcd_valid8), 32'd0);
      check("rst_bcd_out", 32'(bcd_out8), 32'h000);
      rst_n = 1'b1;
      step();

      // 1+4+9 = 14
      beat(0, 4'd1, 0); beat(0, 4'd4, 0); beat(0, 4'd9, 1);
      check("g14_sq_ready_conv", 32'(sq_ready8), 32'd0);
      wait_valid(0, cyc);
      check("g14_latency", 32'(cyc), 32'd8);
      check("g14_out", 32'(bcd_out8), 32'h014);
`ifdef SQBCD_SAT_EN
      check("g14_ovf", 32'(ovf8), 32'd0);
`endif
      step();
      check("g14_valid_drop", 32'(bcd_valid8), 32'd0);
      check("g14_sq_ready_back", 32'(sq_ready8), 32'd1);

      // Backpressure: result held, extra beats ignored
      bcd_ready8 = 1'b0;
      beat(0, 4'd1, 0); beat(0, 4'd4, 0); beat(0, 4'd9, 1);
      wait_valid(0, cyc);
      check("bp_latency", 32'(cyc), 32'd8);
      for (int i = 0; i < 5; i++) begin
         sq_valid8 = 1'b1; sq_in8 = 4'd7; sq_last8 = 1'b1;
         step();
         check("bp_valid_hold", 32'(bcd_valid8), 32'd1);
         check("bp_out_hold", 32'(bcd_out8), 32'h014);
         check("bp_sq_ready", 32'(sq_ready8), 32'd0);
      end
      sq_valid8 = 1'b0; sq_last8 = 1'b0;
      bcd_ready8 = 1'b1;
      step();
      check("bp_release", 32'(bcd_valid8), 32'd0);
      check("bp_out_kept", 32'(bcd_out8), 32'h014);
      beat(0, 4'd4, 1);
      wait_valid(0, cyc);
      check("g4_out", 32'(bcd_out8), 32'h004);
      step();

      // 29 x 9 = 261: saturates to 255 or wraps to 5
      for (int i = 0; i < 28; i++) beat(0, 4'd9, 0);
      beat(0, 4'd9, 1);
      wait_valid(0, cyc);
      check("big_latency", 32'(cyc), 32'd8);
`ifdef SQBCD_SAT_EN
      check("big_out", 32'(bcd_out8), 32'h255);
      check("big_ovf", 32'(ovf8), 32'd1);
`else
      check("big_out", 32'(bcd_out8), 32'h005);
`endif
      step();
`ifdef SQBCD_SAT_EN
      check("big_ovf_clear", 32'(ovf8), 32'd0);
`endif

      // Reset in cycle 3 of CONVERT
      beat(0, 4'd1, 0); beat(0, 4'd4, 0); beat(0, 4'd9, 1);
      step(); step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bcd_valid8), 32'd0);
      check("mid_rst_out", 32'(bcd_out8), 32'h000);
      check("mid_rst_ready", 32'(sq_ready8), 32'd1);
      #2;
      rst_n = 1'b1;
      step();
      check("post_rst_valid", 32'(bcd_valid8), 32'd0);
      beat(0, 4'd9, 1);
      wait_valid(0, cyc);
      check("g9_latency", 32'(cyc), 32'd8);
      check("g9_out", 32'(bcd_out8), 32'h009);
      step();

      // Single zero beat
      beat(0, 4'd0, 1);
      wait_valid(0, cyc);
      check("g0_latency", 32'(cyc), 32'd8);
      check("g0_out", 32'(bcd_out8), 32'h000);
      check("g0_valid", 32'(bcd_valid8), 32'd1);
      step();

      // ACC_W=4: 9+4 = 13, fits in 4 bits
      beat(1, 4'd9, 0); beat(1, 4'd4, 1);
      wait_valid(1, cyc);
      check("w4_latency", 32'(cyc), 32'd4);
      check("w4_out", 32'(bcd_out4), 32'h013);
      step();
      check("w4_valid_drop", 32'(bcd_valid4), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
